// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and byte-lane merge for the CPU data-memory path.
package cpu_mem_pkg;
    localparam int BE_W = 4;
    typedef struct packed {
        logic [31:0]     addr;
        logic [BE_W-1:0] be;
        logic [31:0]     data;
        logic            valid;
    } sb_entry_t;
    function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [BE_W-1:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < BE_W; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO in front of the data memory.
// Loads take the memory port first and see buffered stores forwarded per byte.
module store_buffer
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [31:0]                st_addr,
    input  logic [3:0]                 st_be,
    input  logic [31:0]                st_wdata,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    output logic [31:0]                ld_rdata,
    output logic [AW-1:0]              mem_addr,
    output logic [31:0]                mem_wd,
    output logic                       mem_we,
    input  logic [31:0]                mem_rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    sb_entry_t     buf_q [DEPTH];
    sb_entry_t     buf_d [DEPTH];
    sb_entry_t     head_e;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] ld_word, st_word;
    logic          push, pop;
    logic          unused_ok;

    assign unused_ok = ^{st_addr[31:AW+2], st_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};

    always_comb begin
        ld_word  = ld_addr[AW+1:2];
        st_word  = st_addr[AW+1:2];
        head_e   = buf_q[head_q];
        count    = count_q;
        empty    = count_q == '0;
        st_ready = count_q != CW'(DEPTH);
        push     = st_valid && st_ready && st_be != '0;
        pop      = !ld_valid && !empty;
        mem_we   = pop;
        mem_addr = ld_valid ? ld_word : pop ? head_e.addr[AW-1:0] : '0;
    end

    // Walk entries oldest to youngest so the youngest store wins each byte.
    always_comb begin
        mem_wd   = pop ? be_merge(mem_rdata, head_e.data, head_e.be) : '0;
        ld_rdata = mem_rdata;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q && buf_q[idx].valid && buf_q[idx].addr == 32'(ld_word))
                ld_rdata = be_merge(ld_rdata, buf_q[idx].data, buf_q[idx].be);
        end
    end

    always_comb begin
        buf_d = buf_q;
        if (pop) buf_d[head_q].valid = 1'b0;
        if (push) buf_d[tail_q] = '{addr: 32'(st_word), be: st_be, data: st_wdata, valid: 1'b1};
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stimulus against a queue-based model.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 12;

    logic          clk = 1'b0, reset = 1'b1;
    logic          st_valid = 1'b0, st_ready, ld_valid = 1'b0, mem_we, empty;
    logic [31:0]   st_addr = '0, st_wdata = '0, ld_addr = '0, ld_rdata, mem_wd, mem_rdata;
    logic [3:0]    st_be = '0;
    logic [AW-1:0] mem_addr;
    logic [2:0]    count;
    logic          armed = 1'b0;
    int            n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_be(st_be), .st_wdata(st_wdata),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_rdata(ld_rdata),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .empty(empty), .count(count)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h11223344 : 32'hC0DE0000 + 32'(i);
    endfunction

    // Data memory: combinational read, write at the clock edge.
    logic [31:0] mem [4096];
    assign mem_rdata = mem[mem_addr];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
        forever begin
            @(posedge clk);
            if (mem_we === 1'b1) mem[mem_addr] <= mem_wd;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    typedef struct {
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   d;
    } ent_t;
    ent_t        q[$];
    logic [31:0] ref_mem [4096];

    // Reference model: FIFO of pending stores plus a shadow memory.
    initial begin
        logic [AW-1:0] la, ea;
        logic [31:0]   fwd, ewd;
        logic          ewe, acc;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (armed) begin
                la  = ld_addr[AW+1:2];
                acc = st_valid && q.size() < DEPTH && st_be != 4'b0;
                chk("count", 32'(count), 32'(q.size()));
                chk("empty", 32'(empty), 32'(q.size() == 0));
                chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
                ewe = !ld_valid && q.size() > 0;
                ea  = ld_valid ? la : ewe ? q[0].a : '0;
                ewd = ewe ? lanes(ref_mem[ea], q[0].d, q[0].be) : 32'h0;
                chk("mem_we", 32'(mem_we), 32'(ewe));
                chk("mem_addr", 32'(mem_addr), 32'(ea));
                if (!ld_valid) chk("mem_wd", mem_wd, ewd);
                if (ld_valid) begin
                    fwd = ref_mem[la];
                    foreach (q[k]) if (q[k].a == la) fwd = lanes(fwd, q[k].d, q[k].be);
                    chk("ld_rdata", ld_rdata, fwd);
                end
                if (ewe) begin
                    ref_mem[ea] = ewd;
                    void'(q.pop_front());
                end
                if (reset) q.delete();
                else if (acc) q.push_back('{a: st_addr[AW+1:2], be: st_be, d: st_wdata});
            end
        end
    end

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [3:0] be,
                         input logic [31:0] wd, input logic lv, input logic [31:0] la);
        st_valid = sv; st_addr = sa; st_be = be; st_wdata = wd; ld_valid = lv; ld_addr = la;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mism;
        logic [31:0] w;
        drive(0, 0, 0, 0, 0, 0);
        step; step;
        reset = 1'b0;
        armed = 1'b1;
        #2;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_ld_rdata", ld_rdata, 32'hC0DE0000);
        step;
        // Single byte store merged into an existing word.
        drive(1, 32'h10, 4'b0001, 32'h000000AB, 0, 0);
        step;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("t2_we", 32'(mem_we), 32'd1);
        chk("t2_addr", 32'(mem_addr), 32'd4);
        chk("t2_wd", mem_wd, 32'h112233AB);
        step;
        #2 chk("t2_empty", 32'(empty), 32'd1);
        // Two stores to one word, load forwards youngest byte.
        drive(1, 32'h20, 4'b1111, 32'hAAAAAAAA, 1, 32'h100);
        step;
        drive(1, 32'h20, 4'b0010, 32'h0000BB00, 1, 32'h100);
        step;
        drive(0, 0, 0, 0, 1, 32'h20);
        #2;
        chk("t3_ld_rdata", ld_rdata, 32'hAAAABBAA);
        chk("t3_we", 32'(mem_we), 32'd0);
        step;
        drive(0, 0, 0, 0, 0, 0);
        step; step;
        // Fill under loads, then release.
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h40 + 32'(4 * k), 4'hF, 32'(k + 1), 1, 32'h200);
            step;
        end
        drive(1, 32'h50, 4'hF, 32'd5, 1, 32'h200);
        #2;
        chk("t4_count", 32'(count), 32'd4);
        chk("t4_st_ready", 32'(st_ready), 32'd0);
        step;
        drive(1, 32'h50, 4'hF, 32'd5, 0, 0);
        #2;
        chk("t4_addr0", 32'(mem_addr), 32'h10);
        chk("t4_stall", 32'(st_ready), 32'd0);
        step;
        #2;
        chk("t4_addr1", 32'(mem_addr), 32'h11);
        chk("t4_accept", 32'(st_ready), 32'd1);
        step;
        drive(0, 0, 0, 0, 0, 0);
        #2 chk("t4_addr2", 32'(mem_addr), 32'h12);
        step;
        #2 chk("t4_addr3", 32'(mem_addr), 32'h13);
        step;
        #2 chk("t4_addr4", 32'(mem_addr), 32'h14);
        step;
        #2 chk("t4_empty", 32'(empty), 32'd1);
        // Push and drain together with two held.
        drive(1, 32'h60, 4'hF, 32'h60, 1, 32'h300);
        step;
        drive(1, 32'h64, 4'hF, 32'h64, 1, 32'h300);
        step;
        drive(1, 32'h68, 4'hF, 32'h68, 0, 0);
        #2 chk("t5_count_pre", 32'(count), 32'd2);
        step;
        drive(0, 0, 0, 0, 0, 0);
        #2 chk("t5_count_post", 32'(count), 32'd2);
        step; step; step;
        // Reset with three entries held.
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h70 + 32'(4 * k), 4'hF, 32'h700 + 32'(k), 1, 32'h400);
            step;
        end
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #2;
        chk("t6_we", 32'(mem_we), 32'd1);
        chk("t6_addr", 32'(mem_addr), 32'h1C);
        step;
        reset = 1'b0;
        #2;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_we_after", 32'(mem_we), 32'd0);
        step; step; step;
        // Random traffic over a small set of words.
        for (int n = 0; n < 3000; n++) begin
            w = ($urandom & 32'hFFFFC003) | (32'($urandom_range(0, 15)) << 2);
            drive(1'($urandom_range(0, 1)), w, 4'($urandom), $urandom,
                  $urandom_range(0, 4) < 2,
                  ($urandom & 32'hFFFFC003) | (32'($urandom_range(0, 15)) << 2));
            reset = $urandom_range(0, 199) == 0;
            step;
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 10; n++) step;
        mism = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_final", 32'(mism), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store buffer between the CPU memory stage and the single-port, word-addressed data memory. It accepts byte-enabled stores into a small FIFO and retires them to memory in background cycles with a one-cycle read-merge-write. Loads are served the same cycle from memory, with byte-granular forwarding from all buffered stores, so the CPU never waits on a store unless the buffer is full. Sits directly upstream of the data memory; owns that memory's address, write-data and write-enable inputs.

## Interface
- DEPTH, 4: buffer entries (power of two, ≥2)
- AW, 12: memory word-address width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- st_valid  in  1  store request
- st_ready  out  1  store accepted this cycle when high together with st_valid
- st_addr  in  32  store byte address; word index = st_addr[AW+1:2], other bits ignored
- st_be  in  4  byte enables, bit i = lane [8i+7:8i]
- st_wdata  in  32  lane-aligned store data
- ld_valid  in  1  load request, always served same cycle
- ld_addr  in  32  load byte address, word index as for stores
- ld_rdata  out  32  full merged word (CPU extracts/extends)
- mem_addr  out  AW  memory word address
- mem_wd  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  32  memory combinational read data at mem_addr
- empty  out  1  no entries held
- count  out  $clog2(DEPTH+1)  entries held

## Operation
- Entry = {word addr AW, be 4, data 32, valid}; circular FIFO, head/tail pointers wrap modulo DEPTH.
- Push: st_valid && st_ready at edge writes entry at tail; st_ready = (count != DEPTH). Store with st_be == 0 is accepted but not enqueued.
- Memory port priority: load > drain > idle.
  - Load cycle (ld_valid): mem_addr = ld word, mem_we = 0; no drain.
  - Drain cycle (!ld_valid && !empty): mem_addr = head addr, mem_wd = merge(mem_rdata, head.data, head.be), mem_we = 1; head pops at edge.
  - Idle: mem_addr = 0, mem_we = 0, mem_wd = 0.
- Forwarding: ld_rdata starts from mem_rdata; every held entry with matching addr is applied oldest-to-youngest, each enabled byte overriding, so youngest wins per byte. Store entering in the same cycle is not visible to that load.
- No coalescing; duplicate addresses occupy separate entries.
- Push and pop in same cycle: count unchanged. Push while full: impossible (st_ready low); st_valid held by CPU.
- Outputs mem_*, ld_rdata, st_ready combinational from state and inputs; state only in FIFO registers and pointers.

## Timing
- Reset (edge with reset=1): all valid bits, head, tail, count cleared; pending stores discarded. After reset: empty=1, count=0, st_ready=1, mem_we=0, mem_addr=0, mem_wd=0, ld_rdata=mem_rdata(0 word).
- Store accepted at edge N: visible to loads from cycle N+1; earliest memory write at edge N+1 (if no load in cycle N+1).
- Drain throughput: one entry per non-load cycle; continuous loads starve drain (accepted; CPU must hold a non-load cycle to flush, observable via empty).
- Load latency: zero cycles (combinational), independent of buffer state.
- reset asserted mid-drain: the write of that cycle still occurs if mem_we was high before edge (memory samples same edge); buffer cleared regardless.

## Structure
- Shared package cpu_mem_pkg: sb_entry_t typedef, BE_W=4 constant, function be_merge(old, new, be) used for both drain merge and forwarding.
- No sub-module; FIFO storage and forwarding loop inline.

## Test plan
- Reset then idle: empty=1, count=0, st_ready=1, mem_we=0; memory unchanged.
- Store addr 0x10, be 4'b0001, data 0x000000AB over mem word 0x11223344; next cycle no load -> mem_we=1, mem_addr=4, mem_wd=0x112233AB; then empty=1.
- Two stores to 0x20 (be 4'b1111 data 0xAAAAAAAA, then be 4'b0010 data 0x0000BB00), load 0x20 while both held -> ld_rdata=0xAAAABBAA, mem_we=0 that cycle.
- Fill 4 stores under continuous loads -> count=4, st_ready=0, fifth store stalls; drop loads -> four consecutive writes in FIFO order, fifth accepted after first pop.
- Push and drain in same cycle with count=2 -> count stays 2, pointers wrap correctly past DEPTH-1.
- reset with 3 entries held -> count=0, no further mem_we; memory holds only writes completed before reset edge.
